rram_input_fifo: RTL and testbench
==================================

RRAM_INPUT_FIFO -- requirements
Module: rram_input_fifo

Interface
REQ-001 The module SHALL have one clock, clk, and an asynchronous, active-low reset, rst.
REQ-002 Parameter DATA_WIDTH SHALL default to 16; it sets the word width.
REQ-003 Parameter ADDR_WIDTH SHALL default to 6; DEPTH SHALL be derived as 2**ADDR_WIDTH entries.
REQ-004 Parameter AF_LEVEL SHALL default to DEPTH-4; almost_full asserts when count >= AF_LEVEL.
REQ-005 Parameter AE_LEVEL SHALL default to 4; almost_empty asserts when count <= AE_LEVEL.
REQ-006 Ports SHALL be, one per line:
- clk  in  1  clock, rising edge.
- rst  in  1  async reset, active low.
- wr_cs  in  1  write chip select.
- wr_en  in  1  write enable.
- data_in  in  DATA_WIDTH  write data.
- rd_cs  in  1  read chip select.
- rd_en  in  1  read enable.
- flush  in  1  synchronous clear of contents.
- clr_err  in  1  clears the sticky error flags.
- data_out  out  DATA_WIDTH  read data.
- data_valid  out  1  data_out holds a popped/head word.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Function
REQ-007 push SHALL be wr_cs & wr_en & !full; pop SHALL be rd_cs & rd_en & !empty.
REQ-008 Write and read pointers SHALL be internal, ADDR_WIDTH bits wide, and wrap from DEPTH-1 to 0; there SHALL be no external address inputs.
REQ-009 On push, data_in SHALL be written at wr_ptr and wr_ptr SHALL increment on the same edge.
REQ-010 On pop (non-FWFT), the word at rd_ptr SHALL appear on data_out one cycle later with data_valid high for exactly one cycle; rd_ptr SHALL increment.
REQ-011 Without pop, data_out SHALL hold its last value and data_valid SHALL be 0 (non-FWFT).
REQ-012 Simultaneous push and pop SHALL leave count unchanged; push alone SHALL add 1; pop alone SHALL subtract 1.
REQ-013 Write while full SHALL be dropped, with no change to storage, pointers or count.
REQ-014 Read while empty SHALL be ignored, with no change to pointers or data_out.
REQ-015 A push in the same cycle as the pop that frees the last full slot SHALL be dropped, because full is evaluated pre-edge.
REQ-016 A write attempt (wr_cs & wr_en) while full SHALL set overflow; a read attempt while empty SHALL set underflow.
REQ-017 The error flags SHALL hold until clr_err, flush or reset.
REQ-018 If clr_err coincides with a new error event, the flag SHALL remain set.
REQ-019 flush SHALL have priority over push and pop: next cycle, pointers = 0, count = 0, data_valid = 0, and both error flags cleared.
REQ-020 flush SHALL leave storage unmodified.
REQ-021 All status outputs SHALL be registered or derived combinationally from registered count only.

Reset
REQ-022 While rst = 0, the block SHALL asynchronously force: pointers = 0, count = 0, data_out = 0, data_valid = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0, overflow = 0, underflow = 0.
REQ-023 The storage array SHALL NOT be reset.
REQ-024 Reset asserted mid-burst SHALL discard all contents; the first push after release SHALL be read back first.

Configuration
REQ-025 When RRAM_FIFO_FWFT_EN is defined, the FIFO SHALL operate first-word-fall-through:
- data_out SHALL present the head word whenever !empty, with data_valid = !empty.
- pop SHALL advance to the next word on the following cycle.
- A push into an empty FIFO SHALL appear on data_out one cycle after the write edge.
REQ-026 When RRAM_FIFO_FWFT_EN is undefined, the REQ-010/REQ-011 one-cycle registered read SHALL apply.

Verification (DATA_WIDTH=16, ADDR_WIDTH=3, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2, non-FWFT unless noted)
REQ-027 Push 0x0001..0x0008 -> full=1 and count=8; then pop 8 times -> data_out 0x0001..0x0008 in order, each one cycle after its pop, ending with empty=1.
REQ-028 Fill to 8, then push 0xDEAD -> dropped, overflow=1, count=8; then pop 8 times -> 0xDEAD never appears; clr_err -> overflow=0.
REQ-029 At count=3, hold push and pop together for 20 cycles -> count stays 3, pointers wrap, and data order is preserved; almost_empty toggles at count 2/3 and almost_full at 5/6 during ramps.
REQ-030 Pop while empty -> underflow=1 and data_out unchanged; flush at count=5 -> next cycle count=0, empty=1, underflow=0.
REQ-031 With RRAM_FIFO_FWFT_EN defined, push 0x00A5 into empty -> next cycle data_out=0x00A5 and data_valid=1 with no pop; pop -> empty=1 and data_valid=0.
REQ-032 Assert rst low at count=4 mid-burst -> all outputs at their REQ-022 values immediately; after release, push 0x1234 and pop -> data_out=0x1234.

Source files
------------

// File: rtl/rram_input_fifo.sv
// Synchronous single-clock input FIFO with internal wrapping pointers, occupancy
// status and sticky error flags. Define RRAM_FIFO_FWFT_EN for first-word-fall-through reads.
module rram_input_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 4,
  parameter int AE_LEVEL   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_cs,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_cs,
  input  logic                  rd_en,
  input  logic                  flush,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [ADDR_WIDTH:0]   DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   AF_L    = AF_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   AE_L    = AE_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;

  logic wr_try;
  logic rd_try;
  logic push;
  logic pop;

  // Status decodes only the registered count, so it is glitch-free relative to the clock.
  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_full  = (count >= AF_L);
  assign almost_empty = (count <= AE_L);

  assign wr_try = wr_cs & wr_en;
  assign rd_try = rd_cs & rd_en;
  assign push   = wr_try & ~full & ~flush;
  assign pop    = rd_try & ~empty & ~flush;

  // NOTE: storage has no reset so it maps onto plain RAM; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // NOTE: all sequential state uses non-blocking assignment so every block sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // A fresh error in the same cycle as clr_err wins, so no event is ever lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow  & ~clr_err) | (wr_try & full);
      underflow <= (underflow & ~clr_err) | (rd_try & empty);
    end
  end

`ifdef RRAM_FIFO_FWFT_EN
  assign data_out   = empty ? '0 : mem[rd_ptr];
  assign data_valid = ~empty;
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else if (flush) begin
      data_valid <= 1'b0;
    end else begin
      data_valid <= pop;
      if (pop) data_out <= mem[rd_ptr];
    end
  end
`endif

endmodule

// File: tb/tb_rram_input_fifo.sv
// Randomised and directed bench for rram_input_fifo (registered-read build),
// compared against a queue-based reference model.
module tb_rram_input_fifo;

  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic          clk;
  logic          rst;
  logic          wr_cs, wr_en, rd_cs, rd_en, flush, clr_err;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          data_valid, empty, full, almost_full, almost_empty;
  logic [AW:0]   count;
  logic          overflow, underflow;

  rram_input_fifo #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .AF_LEVEL  (AF),
    .AE_LEVEL  (AE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_cs       (wr_cs),
    .wr_en       (wr_en),
    .data_in     (data_in),
    .rd_cs       (rd_cs),
    .rd_en       (rd_en),
    .flush       (flush),
    .clr_err     (clr_err),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: contents as a queue, plus the expected registered outputs.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_dout;
  logic          exp_valid;
  logic          exp_ovf;
  logic          exp_unf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_dout  = '0;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    exp_unf   = 1'b0;
  endtask

  task automatic check_all(input string tag);
    int n;
    n = mq.size();
    check({tag, ".count"},        32'(count),        32'(n));
    check({tag, ".empty"},        32'(empty),        32'(n == 0));
    check({tag, ".full"},         32'(full),         32'(n == DEPTH));
    check({tag, ".almost_full"},  32'(almost_full),  32'(n >= AF));
    check({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= AE));
    check({tag, ".data_out"},     32'(data_out),     32'(exp_dout));
    check({tag, ".data_valid"},   32'(data_valid),   32'(exp_valid));
    check({tag, ".overflow"},     32'(overflow),     32'(exp_ovf));
    check({tag, ".underflow"},    32'(underflow),    32'(exp_unf));
  endtask

  // One clock cycle: drive inputs, advance the model by the FIFO rules, compare after the edge.
  task automatic cycle(input string tag, input logic wcs, input logic wen, input logic [DW-1:0] din,
                       input logic rcs, input logic ren, input logic fl, input logic clr);
    logic was_full, was_empty;
    wr_cs = wcs; wr_en = wen; data_in = din;
    rd_cs = rcs; rd_en = ren; flush = fl; clr_err = clr;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    if (fl) begin
      mq.delete();
      exp_valid = 1'b0;
      exp_ovf   = 1'b0;
      exp_unf   = 1'b0;
    end else begin
      exp_ovf = (exp_ovf & ~clr) | (wcs & wen & was_full);
      exp_unf = (exp_unf & ~clr) | (rcs & ren & was_empty);
      if (rcs && ren && !was_empty) begin
        exp_dout  = mq.pop_front();
        exp_valid = 1'b1;
      end else begin
        exp_valid = 1'b0;
      end
      if (wcs && wen && !was_full) mq.push_back(din);
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic push(input string tag, input logic [DW-1:0] d);
    cycle(tag, 1'b1, 1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop(input string tag);
    cycle(tag, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    wr_cs = 1'b0; wr_en = 1'b0; data_in = '0;
    rd_cs = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    #3 rst = 1'b1;

    // In-order fill and drain.
    for (int i = 1; i <= 8; i++) push("fill", 16'(i));
    for (int i = 0; i < 8; i++) pop("drain");
    idle("drain_idle");

    // Overflow: write while full is dropped and flagged; clr_err clears.
    for (int i = 0; i < 8; i++) push("ovf_fill", 16'(16'h0100 + i));
    push("ovf_dead", 16'hDEAD);
    for (int i = 0; i < 8; i++) pop("ovf_drain");
    cycle("ovf_clr", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Push with the pop that frees the last slot: the push is dropped.
    for (int i = 0; i < 8; i++) push("edge_fill", 16'(16'h0200 + i));
    cycle("edge_pushpop", 1'b1, 1'b1, 16'hBEEF, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle("edge_clr", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) pop("edge_drain");

    // Steady push+pop at count 3, then ramps across both thresholds.
    for (int i = 0; i < 3; i++) push("pp_pre", 16'(16'h0300 + i));
    for (int i = 0; i < 20; i++)
      cycle("pp_hold", 1'b1, 1'b1, 16'(16'h0400 + i), 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) push("ramp_up", 16'(16'h0500 + i));
    for (int i = 0; i < 8; i++) pop("ramp_down");

    // Underflow holds data_out; flush at count 5 clears everything.
    pop("unf_pop");
    for (int i = 0; i < 5; i++) push("fl_fill", 16'(16'h0600 + i));
    cycle("flush", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    push("post_flush_push", 16'h0777);
    pop("post_flush_pop");

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 4; i++) push("rst_fill", 16'($urandom));
    pop("rst_pop");
    push("rst_fill2", 16'h0888);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    #1 rst = 1'b1;
    push("rst_push", 16'h1234);
    pop("rst_readback");
    idle("rst_idle");

    // Randomised phases with shifting write/read bias.
    for (int ph = 0; ph < 30; ph++) begin
      int wbias, rbias;
      wbias = $urandom_range(10, 90);
      rbias = $urandom_range(10, 90);
      for (int i = 0; i < 80; i++) begin
        cycle("rand",
              1'($urandom_range(0, 99) < 90), 1'($urandom_range(0, 99) < wbias), 16'($urandom),
              1'($urandom_range(0, 99) < 90), 1'($urandom_range(0, 99) < rbias),
              1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 19) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
